pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_pkg.sv | 21 ++
 rtl/pci_arbiter_if.sv | 27 ++
 rtl/rr_pick.sv | 28 ++
 rtl/pci_arbiter.sv | 110 +++++++++++
 tb/tb_pci_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus arbiter: FSM state type, bus command
// codes and the default number of requesting devices.
package pci_pkg;

  localparam int N_MASTERS_DEFAULT = 4;

  localparam logic [3:0] CMD_IO_READ  = 4'b0010;
  localparam logic [3:0] CMD_IO_WRITE = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arbState_e;

  // Index width that stays legal even for a single-device bus.
  function automatic int ownerWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_arbiter_if.sv
// Arbiter-facing PCI signals: requests and shared FRAME#/IRDY# in, grants and
// ownership status out.
interface pci_arbiter_if #(
  parameter int N_MASTERS = pci_pkg::N_MASTERS_DEFAULT
) ();

  localparam int OW = pci_pkg::ownerWidth(N_MASTERS);

  logic [N_MASTERS-1:0] Req_low;
  logic                 Frame_low;
  logic                 IRDY_low;
  logic [N_MASTERS-1:0] GNT_low;
  logic [OW-1:0]        bus_owner;
  logic                 owner_valid;
  logic                 timeout_pulse;

  modport master (
    output Req_low, Frame_low, IRDY_low,
    input  GNT_low, bus_owner, owner_valid, timeout_pulse
  );

  modport slave (
    input  Req_low, Frame_low, IRDY_low,
    output GNT_low, bus_owner, owner_valid, timeout_pulse
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 (wrapping) and returns
// the first device whose active-low request is asserted.
module rr_pick #(
  parameter int N_MASTERS = pci_pkg::N_MASTERS_DEFAULT,
  localparam int OW = pci_pkg::ownerWidth(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] reqLow_i,
  input  logic [OW-1:0]        ptr_i,
  output logic [OW-1:0]        winner_o,
  output logic                 anyReq_o
);

  logic [OW-1:0] idx;

  always_comb begin
    winner_o = '0;
    anyReq_o = 1'b0;
    idx      = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = OW'((int'(ptr_i) + i) % N_MASTERS);
      if (!anyReq_o && !reqLow_i[idx]) begin
        winner_o = idx;
        anyReq_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with one-hot active-low grants, a grant-wait
// timeout and a mandatory idle turnaround cycle between owners.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int N_MASTERS   = N_MASTERS_DEFAULT,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          Reset_low,
  pci_arbiter_if.slave  bus
);

  localparam int OW = ownerWidth(N_MASTERS);
  localparam int CW = ($clog2(GNT_TIMEOUT) > 4) ? $clog2(GNT_TIMEOUT) : 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);

  arbState_e            state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic [OW-1:0] winner;
  logic          anyReq;
  logic          busIdle, frameSeen, ownerWithdrew, timeoutHit;

  assign busIdle       = bus.Frame_low & bus.IRDY_low;
  assign frameSeen     = ~bus.Frame_low;
  assign ownerWithdrew = bus.Req_low[owner_q];
  assign timeoutHit    = (cnt_q == CNT_LAST);

  rr_pick #(.N_MASTERS(N_MASTERS)) picker (
    .reqLow_i (bus.Req_low),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .anyReq_o (anyReq)
  );

  // ptr resets to the last index so device 0 is first in line.
  always_ff @(posedge clk) begin
    if (!Reset_low) begin
      state_q   <= IDLE;
      gnt_q     <= '1;
      ptr_q     <= OW'(N_MASTERS - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // FRAME is checked first in GRANT so it beats withdrawal and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (busIdle && anyReq) state_d = GRANT;
      GRANT: begin
        if (frameSeen)                        state_d = BUSY;
        else if (ownerWithdrew || timeoutHit) state_d = IDLE;
      end
      BUSY:    if (busIdle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (state_d == GRANT) begin
          gnt_d   = ~(N_MASTERS'(1) << winner);
          owner_d = winner;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (state_d == BUSY) begin
          ptr_d = owner_q;
        end else if (state_d == IDLE) begin
          gnt_d = '1;
          // A voluntary withdrawal is not a timeout, even on the last count.
          if (!ownerWithdrew) begin
            timeout_d = 1'b1;
            ptr_d     = owner_q;
          end
        end
      end
      BUSY:    if (state_d == IDLE) gnt_d = '1;
      default: gnt_d = '1;
    endcase
  end

  assign bus.GNT_low       = gnt_q;
  assign bus.bus_owner     = owner_q;
  assign bus.owner_valid   = ~&gnt_q;
  assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: table of cycle vectors whose expected
// outputs go through a scoreboard queue, plus timeout sequences.
module tb_pci_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic Reset_low;

  always #5 clk = ~clk;

  pci_arbiter_if #(.N_MASTERS(N)) bus ();

  pci_arbiter #(.N_MASTERS(N), .GNT_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .Reset_low (Reset_low),
    .bus       (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       fr;
    logic       ir;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       tmo;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] owner;
    logic       tmo;
  } exp_t;

  vec_t table_q[$];
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   stepId = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] req,
                              input logic fr, input logic ir,
                              input logic [3:0] gnt, input logic [1:0] owner,
                              input logic tmo);
    vec_t v;
    v.rst = rst; v.req = req; v.fr = fr; v.ir = ir;
    v.gnt = gnt; v.owner = owner; v.tmo = tmo;
    return v;
  endfunction

  task automatic compare(input string what, input int id,
                         input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL vec%0d %s got %0h want %0h", id, what, got, want);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the next
  // rising edge should produce.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    Reset_low     = v.rst;
    bus.Req_low   = v.req;
    bus.Frame_low = v.fr;
    bus.IRDY_low  = v.ir;
    e.id    = stepId;
    e.gnt   = v.gnt;
    e.valid = (v.gnt != 4'hF);
    e.owner = v.owner;
    e.tmo   = v.tmo;
    expQ.push_back(e);
    stepId++;
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard empty got 0 want 1");
    end else begin
      e = expQ.pop_front();
      compare("GNT_low", e.id, 8'(bus.GNT_low), 8'(e.gnt));
      compare("owner_valid", e.id, 8'(bus.owner_valid), 8'(e.valid));
      compare("bus_owner", e.id, 8'(bus.bus_owner), 8'(e.owner));
      compare("timeout_pulse", e.id, 8'(bus.timeout_pulse), 8'(e.tmo));
      compare("onehot", e.id, 8'($countones(~bus.GNT_low) <= 1), 8'd1);
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  // Device 1 requests and never raises FRAME; either it times out and is
  // re-granted after a gap, or FRAME arrives exactly on the last count.
  task automatic runTimeout(input bit frameAtEnd);
    for (int t = 0; t < TMO; t++)
      step(mk(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0));
    if (!frameAtEnd) begin
      step(mk(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b1));
      step(mk(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0));
      step(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0));
    end else begin
      step(mk(1'b1, 4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0));
      step(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] g;
    Reset_low     = 1'b0;
    bus.Req_low   = '1;
    bus.Frame_low = 1'b1;
    bus.IRDY_low  = 1'b1;

    // Reset, then a single request from device 0 through a full transaction.
    table_q.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1110, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1110, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0));

    // Everyone requesting: ownership rotates 1,2,3,0 with an idle gap each.
    for (int k = 1; k <= N; k++) begin
      g = ~(4'b0001 << (k % N));
      table_q.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, g, 2'(k % N), 1'b0));
      table_q.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b1, g, 2'(k % N), 1'b0));
      table_q.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, g, 2'(k % N), 1'b0));
      table_q.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'(k % N), 1'b0));
    end

    // Bus held busy by someone else: no grant until FRAME and IRDY both high.
    table_q.push_back(mk(1'b1, 4'b0111, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b0111, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b0111, 1'b1, 1'b0, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0));

    // Reset in the middle of device 3's transaction; device 0 wins afterwards.
    table_q.push_back(mk(1'b1, 4'b0111, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b0));
    table_q.push_back(mk(1'b1, 4'b0111, 1'b0, 1'b0, 4'b0111, 2'd3, 1'b0));
    table_q.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0));

    // Withdrawals before FRAME release the grant without a timeout pulse.
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0));

    // FRAME coinciding with withdrawal keeps the grant.
    table_q.push_back(mk(1'b1, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b0));
    table_q.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0));

    $display("[TB] applying %0d table vectors", table_q.size());
    foreach (table_q[i]) step(table_q[i]);

    runTimeout(1'b0);
    runTimeout(1'b1);

    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard leftover got %0d want 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
